// File: rtl/vram_pkg.sv
// Shared defaults and types for the frame-buffer read sequencer.
//   DEF_*          default parameter values for vram_scanout / pix_fifo
//   scan_state_t   sequencer state encoding
//   pix_tag_t      one FIFO entry: pixel data plus frame first/last markers
package vram_pkg;

   localparam int DEF_DATAW        = 24;
   localparam int DEF_ADDR_LENGTH  = 20;
   localparam int DEF_TOTAL_PIXEL  = 921600;
   localparam int DEF_FIFO_DEPTH   = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      FLUSH = 2'd2
   } scan_state_t;

   typedef struct packed {
      logic [DEF_DATAW-1:0] data;
      logic                 first;
      logic                 last;
   } pix_tag_t;

endpackage

// File: rtl/pix_fifo.sv
// Small synchronous FIFO holding tagged pixels between the VRAM read port
// and the downstream valid/ready stream.
//   i_clk, i_rst_n  clock, async active-low reset
//   i_clr           synchronous flush; wins over push/pop
//   i_push, i_data  write one entry (ignored when full)
//   i_pop           drop the head entry (ignored when empty)
//   o_head          current head entry
//   o_count         number of stored entries (0..DEPTH)
//   o_empty         no entries stored
module pix_fifo
   import vram_pkg::*;
#(
   parameter type T     = pix_tag_t,
   parameter int  DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_clr,
   input  logic                   i_push,
   input  T                       i_data,
   input  logic                   i_pop,
   output T                       o_head,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

   T              r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign w_push = i_push && (r_count != CNT_MAX);
   assign w_pop  = i_pop && (r_count != '0);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else if (i_clr) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= r_wr + PTR_ONE;
         end
         if (w_pop) r_rd <= r_rd + PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd];
   assign o_count = r_count;
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/vram_scanout.sv
// Read-side frame-buffer sequencer. Walks the VRAM read port once per
// frameStart, absorbs the one-cycle read latency in pix_fifo and presents
// pixels on a valid/ready stream with first/last markers.
//   readClk, rstN           clock, async active-low reset
//   frameStart              start, or restart when busy
//   readEn, readPointer     VRAM read port (pointer is 1-based)
//   dataOut                 VRAM read data, valid the cycle after readEn
//   pixData/Valid/Ready     downstream pixel stream
//   pixFirst, pixLast       head pixel came from pointer 1 / totalPixel
//   frameDone               one-cycle pulse after the pixLast handshake
//   busy                    frame in progress (SCAN or FLUSH)
//
// state | meaning
// IDLE  | waiting for frameStart
// SCAN  | issuing reads, paced by FIFO credit
// FLUSH | all reads issued, draining until pixLast is accepted
module vram_scanout
   import vram_pkg::*;
#(
   parameter int DATAW      = DEF_DATAW,
   parameter int addrLength = DEF_ADDR_LENGTH,
   parameter int totalPixel = DEF_TOTAL_PIXEL,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                  readClk,
   input  logic                  rstN,
   input  logic                  frameStart,
   output logic                  readEn,
   output logic [addrLength-1:0] readPointer,
   input  logic [DATAW-1:0]      dataOut,
   output logic [DATAW-1:0]      pixData,
   output logic                  pixValid,
   input  logic                  pixReady,
   output logic                  pixFirst,
   output logic                  pixLast,
   output logic                  frameDone,
   output logic                  busy
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [addrLength-1:0] PTR_FIRST = addrLength'(1);
   localparam logic [addrLength-1:0] PTR_LAST  = addrLength'(totalPixel);
   localparam logic [CW-1:0]         CREDIT    = CW'(FIFO_DEPTH);

   typedef struct packed {
      logic [DATAW-1:0] data;
      logic             first;
      logic             last;
   } tag_t;

   scan_state_t           r_state;
   logic [addrLength-1:0] r_ptr;
   logic                  r_inflight;
   logic                  r_if_first;
   logic                  r_if_last;
   logic                  r_done;

   logic [CW-1:0] w_count;
   logic          w_empty;
   tag_t          w_head;
   tag_t          w_push_tag;
   logic          w_read_en;
   logic          w_pop;
   logic          w_last_pop;
   logic          w_abort;

   // A same-cycle pop is not counted as credit, so the FIFO can never overflow
   // even though the read in flight lands one cycle later.
   assign w_read_en  = (r_state == SCAN) && ((w_count + CW'(r_inflight)) < CREDIT);
   assign w_abort    = frameStart && (r_state != IDLE);
   assign w_pop      = !w_empty && pixReady;
   assign w_last_pop = w_pop && w_head.last;
   assign w_push_tag = '{data: dataOut, first: r_if_first, last: r_if_last};

   pix_fifo #(
      .T     (tag_t),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (readClk),
      .i_rst_n (rstN),
      .i_clr   (w_abort),
      .i_push  (r_inflight),
      .i_data  (w_push_tag),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_count),
      .o_empty (w_empty)
   );

   always_ff @(posedge readClk or negedge rstN) begin
      if (!rstN) begin
         r_state    <= IDLE;
         r_ptr      <= PTR_FIRST;
         r_inflight <= 1'b0;
         r_if_first <= 1'b0;
         r_if_last  <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         // A read issued in the abort cycle belongs to the old frame; drop it.
         r_inflight <= w_read_en && !w_abort;
         if (w_read_en) begin
            r_if_first <= (r_ptr == PTR_FIRST);
            r_if_last  <= (r_ptr == PTR_LAST);
         end
         if (frameStart) begin
            r_state <= SCAN;
            r_ptr   <= PTR_FIRST;
         end else begin
            case (r_state)
               IDLE: ;
               SCAN: begin
                  if (w_read_en) begin
                     if (r_ptr == PTR_LAST) begin
                        r_ptr   <= PTR_FIRST;
                        r_state <= FLUSH;
                     end else begin
                        r_ptr <= r_ptr + PTR_FIRST;
                     end
                  end
               end
               FLUSH: begin
                  if (w_last_pop) begin
                     r_state <= IDLE;
                     r_done  <= 1'b1;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign readEn      = w_read_en;
   assign readPointer = r_ptr;
   assign pixData     = w_head.data;
   assign pixValid    = !w_empty;
   assign pixFirst    = w_head.first && !w_empty;
   assign pixLast     = w_head.last && !w_empty;
   assign frameDone   = r_done;
   assign busy        = (r_state != IDLE);

endmodule
